// File: rtl/reg12_share_pkg.sv
// Shared types, default widths and the round-robin pick helper
// for the 12-bit shared holding register arbiter.
package reg12_share_pkg;

  typedef enum logic {ARB, LOCKED} state_t;

  localparam int NUM_REQ_D  = 4;
  localparam int DATA_W_D   = 12;
  localparam int MAX_LOCK_D = 8;

  // Returns {found, idx[2:0]}; scans n requesters from ptr upward with wrap.
  function automatic logic [3:0] rr_pick(
    input logic [7:0] req,
    input logic [2:0] ptr,
    input int         n
  );
    logic [3:0] r;
    int         k;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      if (j < n && !r[3]) begin
        k = (int'(ptr) + j) % n;
        if (req[k[2:0]]) r = {1'b1, k[2:0]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reg12_share_arbiter_if.sv
// Requester-side bus of the shared register arbiter:
// requests, lock, data in; grant and register status out.
interface reg12_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 12,
    parameter int OW      = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         q_out;
  logic                      q_valid;
  logic [OW-1:0]             owner;
  logic                      locked;
  logic                      lock_expired;

  modport master (
    output req, lock, wdata,
    input  gnt, q_out, q_valid, owner, locked, lock_expired
  );

  modport slave (
    input  req, lock, wdata,
    output gnt, q_out, q_valid, owner, locked, lock_expired
  );
endinterface

// File: rtl/reg12_share_arbiter_rr_arbiter.sv
// Plain round-robin picker: first set request at or after ptr,
// returned both one-hot and as an index.
module rr_arbiter
  import reg12_share_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);
  logic [7:0] req8;
  logic [2:0] ptr3;
  logic [3:0] pick;

  assign req8    = 8'(req_i);
  assign ptr3    = 3'(ptr_i);
  assign pick    = rr_pick(req8, ptr3, N);
  assign found_o = pick[3];
  assign idx_o   = IW'(pick[2:0]);
  assign gnt_o   = found_o ? ({{(N-1){1'b0}}, 1'b1} << idx_o) : '0;
endmodule

// File: rtl/reg12_share_arbiter.sv
// Round-robin write arbiter and 12-bit holding register with
// bounded per-requester locking.
module reg12_share_arbiter
  import reg12_share_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_D,
    parameter int DATA_W   = DATA_W_D,
    parameter int MAX_LOCK = MAX_LOCK_D
) (
    input logic clk,
    input logic reset,
    reg12_share_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                exp_q, exp_d;
  logic                valid_q;
  logic [DATA_W-1:0]   data_q;

  logic [NUM_REQ-1:0]  a_gnt, gnt;
  logic [IW-1:0]       a_idx, wr_idx;
  logic                a_found, wr_en;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (i == LAST) ? '0 : i + IW'(1);
  endfunction

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req_i  (bus.req),
    .ptr_i  (ptr_q),
    .gnt_o  (a_gnt),
    .idx_o  (a_idx),
    .found_o(a_found)
  );

  // A lock owner bypasses the rotation entirely.
  always_comb begin
    gnt    = '0;
    wr_idx = a_idx;
    if (!reset) begin
      if (state_q == ARB) begin
        if (a_found) gnt = a_gnt;
      end else begin
        wr_idx = owner_q;
        if (bus.req[owner_q])
          gnt = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
      end
    end
  end

  assign wr_en = |gnt;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    exp_d   = 1'b0;
    if (wr_en) owner_d = wr_idx;
    unique case (state_q)
      ARB: begin
        if (wr_en) begin
          ptr_d = nxt(wr_idx);
          if (bus.lock[wr_idx]) begin
            state_d = LOCKED;
            cnt_d   = CW'(1);
          end
        end
      end
      LOCKED: begin
        if (cnt_q == CW'(MAX_LOCK) || !bus.lock[owner_q]) begin
          state_d = ARB;
          ptr_d   = nxt(owner_q);
          cnt_d   = '0;
          exp_d   = (cnt_q == CW'(MAX_LOCK));
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      exp_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      if (wr_en) valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      data_q <= '0;
    else if (wr_en)
      data_q <= bus.wdata[wr_idx*DATA_W +: DATA_W];
  end

  assign bus.gnt          = gnt;
  assign bus.q_out        = data_q;
  assign bus.q_valid      = valid_q;
  assign bus.owner        = owner_q;
  assign bus.locked       = (state_q == LOCKED);
  assign bus.lock_expired = exp_q;
endmodule

// File: tb/tb_reg12_share_arbiter.sv
// Directed bench for reg12_share_arbiter with a write scoreboard
// that predicts q_out/owner one cycle after each expected grant.
module tb_reg12_share_arbiter;
  typedef struct {
    logic [11:0] d;
    logic [1:0]  o;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  exp_t        sbq[$];
  logic [11:0] m_q;
  logic [1:0]  m_owner;
  logic        m_valid;

  reg12_share_arbiter_if #(.NUM_REQ(4), .DATA_W(12)) bus ();

  reg12_share_arbiter #(.NUM_REQ(4), .DATA_W(12), .MAX_LOCK(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_data(input logic [11:0] base);
    for (int i = 0; i < 4; i++) bus.wdata[i*12 +: 12] = base + 12'(i);
  endtask

  task automatic step(input logic rst, input logic [3:0] r,
                      input logic [3:0] l, input logic [3:0] eg,
                      input logic elk, input logic eexp);
    exp_t e;
    reset    = rst;
    bus.req  = r;
    bus.lock = l;
    #3;
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("locked", 32'(bus.locked), 32'(elk));
    chk("lock_expired", 32'(bus.lock_expired), 32'(eexp));
    chk("q_out", 32'(bus.q_out), 32'(m_q));
    chk("owner", 32'(bus.owner), 32'(m_owner));
    chk("q_valid", 32'(bus.q_valid), 32'(m_valid));
    if (!rst && eg != 4'b0) begin
      for (int i = 0; i < 4; i++) begin
        if (eg[i]) begin
          e.d = bus.wdata[i*12 +: 12];
          e.o = 2'(i);
        end
      end
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      sbq.delete();
      m_q = '0; m_owner = '0; m_valid = 1'b0;
    end else if (sbq.size() > 0) begin
      e = sbq.pop_front();
      m_q = e.d; m_owner = e.o; m_valid = 1'b1;
    end
  endtask

  initial begin
    m_q = '0; m_owner = '0; m_valid = 1'b0;
    reset = 1'b1;
    bus.req = 4'hf;
    bus.lock = 4'h0;
    set_data(12'h100);
    @(posedge clk);
    #1;
    // reset with all requesting
    step(1, 4'hf, 4'h0, 4'h0, 0, 0);
    step(1, 4'hf, 4'h0, 4'h0, 0, 0);
    // rotation
    step(0, 4'hf, 4'h0, 4'h1, 0, 0);
    step(0, 4'hf, 4'h0, 4'h2, 0, 0);
    step(0, 4'hf, 4'h0, 4'h4, 0, 0);
    step(0, 4'hf, 4'h0, 4'h8, 0, 0);
    step(0, 4'hf, 4'h0, 4'h1, 0, 0);
    // sparse requests with wrap
    step(0, 4'h3, 4'h0, 4'h2, 0, 0);
    step(0, 4'h3, 4'h0, 4'h1, 0, 0);
    step(0, 4'h3, 4'h0, 4'h2, 0, 0);
    step(0, 4'h0, 4'h0, 4'h0, 0, 0);
    step(0, 4'h1, 4'h0, 4'h1, 0, 0);
    // lock by requester 1
    set_data(12'h200);
    step(0, 4'hf, 4'h2, 4'h2, 0, 0);
    step(0, 4'hf, 4'h2, 4'h2, 1, 0);
    step(0, 4'hf, 4'h2, 4'h2, 1, 0);
    step(0, 4'hf, 4'h0, 4'h2, 1, 0);
    step(0, 4'hf, 4'h0, 4'h4, 0, 0);
    // timeout of requester 3
    set_data(12'h300);
    step(0, 4'hf, 4'h8, 4'h8, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 4'hf, 4'h8, 4'h8, 1, 0);
    step(0, 4'hf, 4'h8, 4'h1, 0, 1);
    step(0, 4'hf, 4'h8, 4'h2, 0, 0);
    step(0, 4'hf, 4'h8, 4'h4, 0, 0);
    step(0, 4'hf, 4'h8, 4'h8, 0, 0);
    step(0, 4'h0, 4'h0, 4'h0, 1, 0);
    // reset while requester 2 holds a lock
    set_data(12'h400);
    step(0, 4'h4, 4'h4, 4'h4, 0, 0);
    step(1, 4'h4, 4'h4, 4'h0, 1, 0);
    set_data(12'ha50);
    step(0, 4'hf, 4'h0, 4'h1, 0, 0);
    step(0, 4'hf, 4'h0, 4'h2, 0, 0);
    step(0, 4'h0, 4'h0, 4'h0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/reg12_share_arbiter.md
# reg12_share_arbiter

Round-robin write arbiter that shares one 12-bit holding register among several requesters. Each cycle it grants at most one requester, captures that requester's data into the register, and reports who wrote it. A requester may lock the register for back-to-back writes, bounded by a timeout. It sits in front of the 12-bit storage register and is its only write path.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- DATA_W, 12: register width
- MAX_LOCK, 8: maximum consecutive cycles one requester may hold a lock, ≥1
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req  in  NUM_REQ  write request, one bit per requester
- lock  in  NUM_REQ  request to keep ownership after this grant
- wdata  in  NUM_REQ*DATA_W  requester i data at [i*DATA_W +: DATA_W]
- gnt  out  NUM_REQ  one-hot write acknowledge, combinational
- q_out  out  DATA_W  register contents
- q_valid  out  1  at least one write since reset
- owner  out  $clog2(NUM_REQ)  index of the last writer, or of the lock holder while locked
- locked  out  1  state is LOCKED
- lock_expired  out  1  one-cycle pulse when a lock is forcibly released

## Operation
- States are ARB and LOCKED. Registered `ptr` (round-robin start) and `lock_cnt`.
- **ARB state**
  - gnt selects the first i with req[i]=1, scanning from ptr upward with wrap.
  - No req gives gnt=0.
- **Write on gnt[i]**
  - At the edge: q_out←wdata[i], owner←i, q_valid←1, ptr←(i+1) mod NUM_REQ.
  - If lock[i]=1 at the same time, go to LOCKED with lock_cnt←1.
- **LOCKED state**
  - gnt[owner]=req[owner]. All other gnt bits are 0 and other requests are ignored without being dropped.
  - Each grant writes as in ARB, but ptr stays unchanged.
- **Release: lock[owner]=0 in a LOCKED cycle**
  - Any grant that cycle still writes.
  - Next state is ARB, with ptr←(owner+1) mod NUM_REQ.
- **Timeout: lock_cnt=MAX_LOCK in a LOCKED cycle**
  - Same as a normal release, regardless of lock.
  - lock_expired=1 in the following cycle.
  - Otherwise lock_cnt increments each LOCKED cycle.
- MAX_LOCK=1 means a lock never yields more than one extra cycle.
- Simultaneous release and timeout are handled as a timeout.
- gnt is never asserted for a requester with req=0.
- **Reset values:**
  - q_out=0, q_valid=0, owner=0, locked=0, lock_expired=0, state ARB, ptr=0, lock_cnt=0.
  - gnt=0 while reset=1.
  - Reset mid-lock abandons the lock immediately.

## Timing
- Grant-to-data latency is 1 cycle: gnt[i] is high in cycle n, and q_out shows wdata[i] from cycle n+1.
- The requester must hold req and wdata stable until it sees gnt. A grant is consumed in the same cycle.
- One write per cycle maximum. Full throughput applies for a locked owner or for rotating requesters.
- locked rises the cycle after the locking grant and falls the cycle after release or timeout.
- gnt depends combinationally on req, state, ptr and owner only. It does not depend on wdata or lock.

## Structure
- Package reg12_share_pkg holds:
  - the state enum {ARB, LOCKED};
  - the default widths;
  - the function `rr_pick(req, ptr)`, which returns the index and a found flag.
- One sub-module, rr_arbiter (req, ptr → one-hot gnt, index), is instantiated once. The LOCKED override is muxed outside it.
- The storage register is an enabled DATA_W flop with a synchronous clear, inside this block.

## Test plan
- **Reset:** reset=1 for 2 cycles with all req=1.
  - Required: gnt=0, q_out=0x000, q_valid=0.
  - After release: gnt=0001, and q_out=wdata[0] one cycle later.
- **Rotation:** req=1111 held, data i=0x100+i.
  - Required: gnt sequence 0001,0010,0100,1000,0001.
  - q_out follows with 1-cycle lag.
  - owner sequence 0,1,2,3.
- **Sparse requests:** ptr=2, req=0011.
  - Required: gnt=0001 (wrap). Then ptr=1, so the next grant is 0010.
- **Lock:** req=1111, req1 granted with lock[1]=1 for 3 cycles.
  - Required: gnt=0010 for 4 cycles, locked=1.
  - After lock drops, the next grant is requester 2.
- **Timeout:** MAX_LOCK=8, requester 3 holds req and lock forever, others request.
  - Required: 8 LOCKED cycles, then lock_expired pulse.
  - Next grant goes to requester 0. Requester 3 is re-granted only after 0..2.
- **Reset mid-lock:** reset asserted while locked=1 with owner=2.
  - Required: next cycle locked=0, q_out=0, owner=0.
  - The first grant after reset goes to requester 0.
